// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants and stall-action encoding for the
// pipeline stage registers.
package ex_mem_pipe_pkg;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [7:0]  ALUOP_NOP = 8'h00;

  typedef enum logic [1:0] {
    ACT_FLUSH   = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_ADVANCE = 2'd2,
    ACT_HOLD    = 2'd3
  } pipe_act_e;

endpackage

// File: rtl/pipe_ctl_decode.sv
// Maps controller flush/stall requests onto one
// stage-register action.
module pipe_ctl_decode
  import ex_mem_pipe_pkg::*;
(
  input  logic       flush,
  input  logic       stall_ex,
  input  logic       stall_mem,
  output logic [1:0] act
);

  // Flush wins; stall_ex=0 always advances,
  // even with the illegal stall_mem=1.
  always_comb begin
    act = ACT_HOLD;
    unique case (1'b1)
      flush:
        act = ACT_FLUSH;
      !flush && stall_ex && !stall_mem:
        act = ACT_BUBBLE;
      !flush && !stall_ex:
        act = ACT_ADVANCE;
      !flush && stall_ex && stall_mem:
        act = ACT_HOLD;
      default:
        act = ACT_HOLD;
    endcase
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with stall, flush, bubble
// and multiply-accumulate feedback to EX.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_ex,
  input  logic                  stall_mem,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   ex_hilo_temp,
  input  logic [CNT_W-1:0]      ex_cnt,
  output logic                  mem_valid,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [CNT_W-1:0]      cnt_o
);

  localparam logic [ALUOP_W-1:0] NOP =
    ALUOP_W'(ALUOP_NOP);

  logic [1:0] act;

  pipe_ctl_decode u_dec (
    .flush     (flush),
    .stall_ex  (stall_ex),
    .stall_mem (stall_mem),
    .act       (act)
  );

  // Forward bundle: capture on advance, zero on
  // flush or bubble, keep on hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      mem_valid    <= 1'b0;
      mem_wd       <= '0;
      mem_wreg     <= WRITE_DISABLE;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= WRITE_DISABLE;
      mem_aluop    <= NOP;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
    end else begin
      unique case (act)
        ACT_FLUSH, ACT_BUBBLE: begin
          mem_valid    <= 1'b0;
          mem_wd       <= '0;
          mem_wreg     <= WRITE_DISABLE;
          mem_wdata    <= '0;
          mem_hi       <= '0;
          mem_lo       <= '0;
          mem_whilo    <= WRITE_DISABLE;
          mem_aluop    <= NOP;
          mem_mem_addr <= '0;
          mem_reg2     <= '0;
        end
        ACT_ADVANCE: begin
          mem_valid    <= ex_valid;
          mem_wd       <= ex_wd;
          mem_wreg     <= ex_wreg;
          mem_wdata    <= ex_wdata;
          mem_hi       <= ex_hi;
          mem_lo       <= ex_lo;
          mem_whilo    <= ex_whilo;
          mem_aluop    <= ex_aluop;
          mem_mem_addr <= ex_mem_addr;
          mem_reg2     <= ex_reg2;
        end
        default: begin
        end
      endcase
    end
  end

  // Feedback to EX: keep the partial product only
  // while EX is stalled behind a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end else begin
      unique case (act)
        ACT_BUBBLE: begin
          hilo_temp_o <= ex_hilo_temp;
          cnt_o       <= ex_cnt;
        end
        ACT_FLUSH, ACT_ADVANCE: begin
          hilo_temp_o <= '0;
          cnt_o       <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: default and
// wide (64-bit) instances share control inputs.
module tb_ex_mem_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_ex = 1'b0;
  logic stall_mem = 1'b0;
  logic flush = 1'b0;
  logic ex_valid = 1'b0;
  logic ex_wreg = 1'b0;
  logic ex_whilo = 1'b0;

  logic [4:0]  ex_wd = '0;
  logic [31:0] ex_wdata = '0;
  logic [31:0] ex_hi = '0;
  logic [31:0] ex_lo = '0;
  logic [7:0]  ex_aluop = '0;
  logic [31:0] ex_mem_addr = '0;
  logic [31:0] ex_reg2 = '0;
  logic [63:0] ex_hilo_temp = '0;
  logic [1:0]  ex_cnt = '0;

  logic        mem_valid, mem_wreg, mem_whilo;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  logic [5:0]   w_wd = '0;
  logic [63:0]  w_wdata = '0;
  logic [63:0]  w_hi = '0;
  logic [63:0]  w_lo = '0;
  logic [63:0]  w_addr = '0;
  logic [63:0]  w_reg2 = '0;
  logic [127:0] w_hilo = '0;

  logic         wm_valid, wm_wreg, wm_whilo;
  logic [5:0]   wm_wd;
  logic [63:0]  wm_wdata, wm_hi, wm_lo;
  logic [7:0]   wm_aluop;
  logic [63:0]  wm_addr, wm_reg2;
  logic [127:0] wm_hilo;
  logic [1:0]   wm_cnt;

  int n_chk = 0;
  int n_fail = 0;

  ex_mem_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .stall_ex     (stall_ex),
    .stall_mem    (stall_mem),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_wd        (ex_wd),
    .ex_wreg      (ex_wreg),
    .ex_wdata     (ex_wdata),
    .ex_hi        (ex_hi),
    .ex_lo        (ex_lo),
    .ex_whilo     (ex_whilo),
    .ex_aluop     (ex_aluop),
    .ex_mem_addr  (ex_mem_addr),
    .ex_reg2      (ex_reg2),
    .ex_hilo_temp (ex_hilo_temp),
    .ex_cnt       (ex_cnt),
    .mem_valid    (mem_valid),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .mem_whilo    (mem_whilo),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .hilo_temp_o  (hilo_temp_o),
    .cnt_o        (cnt_o)
  );

  ex_mem_pipe #(
    .DATA_W     (64),
    .REG_ADDR_W (6)
  ) dut_w (
    .clk          (clk),
    .rst          (rst),
    .stall_ex     (stall_ex),
    .stall_mem    (stall_mem),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_wd        (w_wd),
    .ex_wreg      (ex_wreg),
    .ex_wdata     (w_wdata),
    .ex_hi        (w_hi),
    .ex_lo        (w_lo),
    .ex_whilo     (ex_whilo),
    .ex_aluop     (ex_aluop),
    .ex_mem_addr  (w_addr),
    .ex_reg2      (w_reg2),
    .ex_hilo_temp (w_hilo),
    .ex_cnt       (ex_cnt),
    .mem_valid    (wm_valid),
    .mem_wd       (wm_wd),
    .mem_wreg     (wm_wreg),
    .mem_wdata    (wm_wdata),
    .mem_hi       (wm_hi),
    .mem_lo       (wm_lo),
    .mem_whilo    (wm_whilo),
    .mem_aluop    (wm_aluop),
    .mem_mem_addr (wm_addr),
    .mem_reg2     (wm_reg2),
    .hilo_temp_o  (wm_hilo),
    .cnt_o        (wm_cnt)
  );

  always #5 clk = ~clk;

  // The controller must never advance EX while MEM stalls.
  always @(posedge clk) begin
    if (!rst && !flush)
      assert (!(!stall_ex && stall_mem))
        else $error("illegal stall_ex=0 stall_mem=1");
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    chk("rst_valid", 128'(mem_valid), 128'(0));
    chk("rst_wdata", 128'(mem_wdata), 128'(0));
    chk("rst_hilo", 128'(hilo_temp_o), 128'(0));
    chk("rst_cnt", 128'(cnt_o), 128'(0));
    chk("rst_w_wdata", 128'(wm_wdata), 128'(0));
    rst = 1'b0;

    // Advance
    ex_valid = 1'b1;
    ex_wd = 5'd3;
    ex_wreg = 1'b1;
    ex_wdata = 32'h1234_5678;
    ex_aluop = 8'h23;
    ex_mem_addr = 32'h0000_1000;
    ex_reg2 = 32'h0000_0055;
    w_wd = 6'd33;
    w_wdata = 64'h0123_4567_89AB_CDEF;
    step();
    chk("adv_wd", 128'(mem_wd), 128'(3));
    chk("adv_wreg", 128'(mem_wreg), 128'(1));
    chk("adv_wdata", 128'(mem_wdata),
        128'(32'h1234_5678));
    chk("adv_valid", 128'(mem_valid), 128'(1));
    chk("adv_aluop", 128'(mem_aluop), 128'(8'h23));
    chk("adv_addr", 128'(mem_mem_addr),
        128'(32'h1000));
    chk("adv_reg2", 128'(mem_reg2), 128'(32'h55));
    chk("w_adv_wd", 128'(wm_wd), 128'(33));
    chk("w_adv_wdata", 128'(wm_wdata),
        128'(64'h0123_4567_89AB_CDEF));

    // Bubble keeps the partial product
    stall_ex = 1'b1;
    ex_hilo_temp = 64'hFFFF_0000_0000_0001;
    ex_cnt = 2'd1;
    w_hilo = {64'h8000_0000_0000_0002,
              64'h0000_0000_0000_0003};
    step();
    chk("bub_wreg", 128'(mem_wreg), 128'(0));
    chk("bub_valid", 128'(mem_valid), 128'(0));
    chk("bub_wdata", 128'(mem_wdata), 128'(0));
    chk("bub_aluop", 128'(mem_aluop), 128'(0));
    chk("bub_hilo", 128'(hilo_temp_o),
        128'(64'hFFFF_0000_0000_0001));
    chk("bub_cnt", 128'(cnt_o), 128'(1));
    chk("w_bub_hilo", wm_hilo,
        {64'h8000_0000_0000_0002,
         64'h0000_0000_0000_0003});

    stall_ex = 1'b0;
    step();
    chk("res_cnt", 128'(cnt_o), 128'(0));
    chk("res_hilo", 128'(hilo_temp_o), 128'(0));
    chk("w_res_hilo", wm_hilo, 128'(0));
    chk("res_valid", 128'(mem_valid), 128'(1));

    // Hold
    ex_wdata = 32'hCAFE_F00D;
    step();
    chk("ld_wdata", 128'(mem_wdata),
        128'(32'hCAFE_F00D));
    stall_ex = 1'b1;
    stall_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_wdata = 32'h1111_0000 + 32'(i);
      step();
      chk("hold_wdata", 128'(mem_wdata),
          128'(32'hCAFE_F00D));
      chk("hold_valid", 128'(mem_valid), 128'(1));
    end

    // Flush over hold, forward bundle nonzero
    flush = 1'b1;
    step();
    chk("fl_wdata", 128'(mem_wdata), 128'(0));
    chk("fl_valid", 128'(mem_valid), 128'(0));
    chk("fl_wd", 128'(mem_wd), 128'(0));
    flush = 1'b0;

    // Flush over hold, feedback nonzero
    stall_mem = 1'b0;
    ex_hilo_temp = 64'h0000_0001_2345_6789;
    ex_cnt = 2'd2;
    step();
    chk("bub2_cnt", 128'(cnt_o), 128'(2));
    stall_mem = 1'b1;
    ex_cnt = 2'd3;
    step();
    chk("hold_cnt", 128'(cnt_o), 128'(2));
    chk("hold_hilo", 128'(hilo_temp_o),
        128'(64'h0000_0001_2345_6789));
    flush = 1'b1;
    step();
    chk("fl_cnt", 128'(cnt_o), 128'(0));
    chk("fl_hilo", 128'(hilo_temp_o), 128'(0));
    flush = 1'b0;
    stall_ex = 1'b0;
    stall_mem = 1'b0;

    // Async reset between edges
    ex_whilo = 1'b1;
    ex_hi = 32'hA5A5_A5A5;
    ex_lo = 32'h5A5A_5A5A;
    step();
    chk("pre_whilo", 128'(mem_whilo), 128'(1));
    chk("pre_hi", 128'(mem_hi), 128'(32'hA5A5_A5A5));
    chk("pre_lo", 128'(mem_lo), 128'(32'h5A5A_5A5A));
    #3;
    rst = 1'b1;
    #1;
    chk("ar_whilo", 128'(mem_whilo), 128'(0));
    chk("ar_hi", 128'(mem_hi), 128'(0));
    chk("ar_valid", 128'(mem_valid), 128'(0));
    chk("ar_w_wdata", 128'(wm_wdata), 128'(0));
    ex_wdata = 32'h0BAD_BEEF;
    step();
    step();
    chk("rsthold_wdata", 128'(mem_wdata), 128'(0));
    rst = 1'b0;
    step();
    chk("post_wdata", 128'(mem_wdata),
        128'(32'h0BAD_BEEF));
    chk("post_hi", 128'(mem_hi), 128'(32'hA5A5_A5A5));
    chk("post_valid", 128'(mem_valid), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
